mem_arbiter: RTL and testbench

Shares the single-port data RAM between the pipelined ARM core's data port and the camera pixel stream. Camera pixels are buffered in an internal FIFO with auto-incrementing frame addresses. Writes drain into RAM whenever the core is idle or the FIFO crosses an urgency threshold. While the camera owns the RAM, the core is stalled.

---
 rtl/memarb_pkg.sv | 8 +
 rtl/cam_fifo.sv | 38 +++
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// memarb_pkg: shared arbiter state encoding and camera FIFO entry layout
package memarb_pkg;
  typedef enum logic {S_CPU = 1'b0, S_BURST = 1'b1} arb_state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } cam_entry_t;
endpackage

// File: rtl/cam_fifo.sv
// cam_fifo: synchronous FIFO with occupancy count, generic over the entry type
module cam_fifo import memarb_pkg::*; #(
  parameter int  DEPTH = 8,
  parameter type T     = cam_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push & (count != CW'(DEPTH));
  assign do_pop  = pop & (count != '0);
  assign head    = mem[rp];
  // pointers and occupancy; reset drops every queued entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // entry storage, not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the data RAM between the core and a buffered camera stream (MEMARB_STATS_EN adds stall/write counters)
module mem_arbiter import memarb_pkg::*; #(
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 32,
  parameter int                 FIFO_DEPTH = 8,
  parameter int                 CAM_HI     = 6,
  parameter int                 CAM_LO     = 2,
  parameter int                 MAX_BURST  = 4,
  parameter logic [ADDR_W-1:0]  CAM_BASE   = ADDR_W'(32'h0000_4000),
  parameter int                 CAM_WORDS  = 19200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              cam_valid,
  input  logic [DATA_W-1:0] cam_data,
  output logic              cam_ready,
  input  logic              cam_frame_start,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0]       stat_stall_cycles,
  output logic [31:0]       stat_cam_writes
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] CAM_LAST = CAM_BASE + ADDR_W'(CAM_WORDS - 1);
  arb_state_t state, state_n;
  cam_entry_t head, din;
  logic [CW-1:0] count, count_n;
  logic [31:0] bcnt, bnext;
  logic [ADDR_W-1:0] wr_addr, pix_addr;
  logic push, urgent, cam_grant, cpu_grant, in_burst;
  cam_fifo #(.DEPTH(FIFO_DEPTH), .T(cam_entry_t)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .din   (din),
    .pop   (cam_grant),
    .head  (head),
    .count (count)
  );
  assign cam_ready   = count < CW'(FIFO_DEPTH);
  assign push        = cam_valid & cam_ready;
  assign pix_addr    = cam_frame_start ? CAM_BASE : wr_addr;
  assign din         = '{addr: 32'(pix_addr), data: 32'(cam_data)};
  assign urgent      = cpu_req & (count >= CW'(CAM_HI));
  assign cam_grant   = (count != '0) & ((state == S_BURST) | ~cpu_req | urgent);
  assign cpu_grant   = cpu_req & ~cam_grant;
  assign cpu_stall   = cpu_req & ~cpu_grant;
  assign count_n     = count + CW'(push) - CW'(cam_grant);
  // the cycle that enters a burst already counts as one stolen core cycle
  assign bnext       = (state == S_BURST ? bcnt : 32'd0) + 32'(cam_grant & cpu_req);
  assign in_burst    = (state == S_BURST) | urgent;
  assign state_n     = (in_burst & (count_n > CW'(CAM_LO)) & (bnext < 32'(MAX_BURST))) ? S_BURST : S_CPU;
  assign ram_address = cam_grant ? ADDR_W'(head.addr) : cpu_grant ? cpu_addr : '0;
  assign ram_data    = cam_grant ? DATA_W'(head.data) : cpu_grant ? cpu_wdata : '0;
  assign ram_wren    = cam_grant | (cpu_grant & cpu_we);
  assign cpu_rdata   = ram_q;
  // arbitration state, burst length, frame address and read-return flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CPU;
      bcnt       <= '0;
      wr_addr    <= CAM_BASE;
      cpu_rvalid <= 1'b0;
    end else begin
      state      <= state_n;
      bcnt       <= state_n == S_BURST ? bnext : 32'd0;
      wr_addr    <= push ? (pix_addr == CAM_LAST ? CAM_BASE : pix_addr + ADDR_W'(1)) : pix_addr;
      cpu_rvalid <= cpu_grant & ~cpu_we;
    end
  end
`ifdef MEMARB_STATS_EN
  // saturating activity counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_cycles <= '0;
      stat_cam_writes   <= '0;
    end else begin
      stat_stall_cycles <= stat_stall_cycles + 32'(cpu_stall & ~&stat_stall_cycles);
      stat_cam_writes   <= stat_cam_writes + 32'(cam_grant & ~&stat_cam_writes);
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import memarb_pkg::*;
  localparam logic [31:0] BASE  = 32'h0000_4000;
  localparam int          WORDS = 19200;
  logic clk = 0, reset = 1;
  logic cpu_req = 0, cpu_we = 0, cam_valid = 0, cam_frame_start = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cam_data = 0, ram_q = 0;
  logic cpu_stall, cpu_rvalid, cam_ready, ram_wren;
  logic [31:0] cpu_rdata, ram_address, ram_data;
  logic cpu_req2 = 0, cam_valid2 = 0;
  logic [31:0] cam_data2 = 0, ram_q2 = 0;
  logic cpu_stall2, cpu_rvalid2, cam_ready2, ram_wren2;
  logic [31:0] cpu_rdata2, ram_address2, ram_data2;
`ifdef MEMARB_STATS_EN
  logic [31:0] s1a, s1b, s2a, s2b;
`endif
  int vectors = 0, errs = 0;
  logic [31:0] mem [logic [31:0]];
  cam_entry_t exp_q [$];
  cam_entry_t e;
  logic [31:0] exp_wa = BASE, a;
  logic pend = 0;
  logic [31:0] pend_data = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cam_valid(cam_valid), .cam_data(cam_data), .cam_ready(cam_ready), .cam_frame_start(cam_frame_start),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
`ifdef MEMARB_STATS_EN
    , .stat_stall_cycles(s1a), .stat_cam_writes(s1b)
`endif
  );

  mem_arbiter #(.CAM_HI(9), .MAX_BURST(1000)) dut2 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req2), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall2), .cpu_rvalid(cpu_rvalid2), .cpu_rdata(cpu_rdata2),
    .cam_valid(cam_valid2), .cam_data(cam_data2), .cam_ready(cam_ready2), .cam_frame_start(1'b0),
    .ram_address(ram_address2), .ram_data(ram_data2), .ram_wren(ram_wren2), .ram_q(ram_q2)
`ifdef MEMARB_STATS_EN
    , .stat_stall_cycles(s2a), .stat_cam_writes(s2b)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] ad);
    return mem.exists(ad) ? mem[ad] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // RAM model with registered read data
  always @(posedge clk) begin
    ram_q <= rd(ram_address);
    if (ram_wren) mem[ram_address] = ram_data;
  end

  // scoreboard: camera writes in accept order, core reads one cycle later
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_wa = BASE;
      pend = 0;
    end else begin
      chk("rvalid", cpu_rvalid, pend);
      if (pend) chk("rdata", cpu_rdata, pend_data);
      pend = cpu_req & ~cpu_stall & ~cpu_we;
      if (pend) begin
        chk("cpu_addr", ram_address, cpu_addr);
        pend_data = rd(cpu_addr);
      end
      if (ram_wren) begin
        chk("wr_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("cam_addr", ram_address, e.addr);
          chk("cam_data", ram_data, e.data);
        end
      end
      if (cam_valid & cam_ready) begin
        a = cam_frame_start ? BASE : exp_wa;
        exp_q.push_back('{addr: a, data: cam_data});
        exp_wa = (a == BASE + WORDS - 1) ? BASE : a + 1;
      end else if (cam_frame_start) exp_wa = BASE;
    end
  end

  initial begin
    mem[5] = 32'hCAFE_0005;
    mem[7] = 32'h0BAD_F00D;
    cyc(2);
    @(negedge clk);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_ready", cam_ready, 1);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_count", dut.count, 0);
    chk("rst_state", dut.state, S_CPU);
    chk("rst_wr_addr", dut.wr_addr, BASE);
    chk("rst_bcnt", dut.bcnt, 0);
    cyc();
    reset = 0;
    cyc();
    // core read from address 5, camera idle
    cpu_req = 1;
    cpu_addr = 5;
    @(negedge clk);
    chk("ldr_stall", cpu_stall, 0);
    chk("ldr_addr", ram_address, 5);
    chk("ldr_wren", ram_wren, 0);
    cyc();
    cpu_req = 0;
    @(negedge clk);
    chk("ldr_rvalid", cpu_rvalid, 1);
    chk("ldr_rdata", cpu_rdata, 32'hCAFE_0005);
    cyc();
    // three pixels, core idle: written on consecutive cycles one after accept
    cam_valid = 1;
    cam_data = 32'hA0;
    @(negedge clk);
    chk("pix_lat0", ram_wren, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      cam_valid = i < 3;
      cam_data = 32'hA0 + i;
      @(negedge clk);
      chk("pix_wren", ram_wren, 1);
      chk("pix_addr", ram_address, BASE + i - 1);
    end
    cyc();
    @(negedge clk);
    chk("pix_idle", ram_wren, 0);
    cyc();
    // core busy while seven pixels arrive: urgent burst of four stolen cycles
    cpu_req = 1;
    cpu_addr = 7;
    for (int i = 0; i < 12; i++) begin
      cam_valid = i < 7;
      cam_data = 32'h100 + i;
      @(negedge clk);
      chk("burst_stall", cpu_stall, (i >= 6 && i <= 9));
      if (i == 7) chk("burst_state", dut.state, S_BURST);
      if (i == 10) begin
        chk("burst_end_count", dut.count, 3);
        chk("burst_end_state", dut.state, S_CPU);
      end
      cyc();
    end
    cpu_req = 0;
    cam_valid = 0;
    cyc(4);
    @(negedge clk);
    chk("burst_drained", dut.count, 0);
    chk("burst_no_loss", exp_q.size(), 0);
    cyc();
    // FIFO full with urgency disabled: no push until the core lets go
    cpu_req2 = 1;
    cam_valid2 = 1;
    for (int i = 0; i < 11; i++) begin
      cam_data2 = 32'h200 + i;
      @(negedge clk);
      if (i >= 8) begin
        chk("full_ready", cam_ready2, 0);
        chk("full_count", dut2.count, 8);
        chk("full_stall", cpu_stall2, 0);
      end
      cyc();
    end
    cpu_req2 = 0;
    cam_data2 = 32'h300;
    @(negedge clk);
    chk("full_pop_wren", ram_wren2, 1);
    chk("full_pop_addr", ram_address2, BASE);
    chk("full_pop_data", ram_data2, 32'h200);
    chk("full_pop_ready", cam_ready2, 0);
    cyc();
    @(negedge clk);
    chk("full_after_count", dut2.count, 7);
    chk("full_after_ready", cam_ready2, 1);
    chk("full_after_addr", ram_address2, BASE + 1);
    chk("full_after_data", ram_data2, 32'h201);
    cyc();
    cam_valid2 = 0;
    @(negedge clk);
    chk("full_pushpop_count", dut2.count, 7);
    cyc(10);
    @(negedge clk);
    chk("full_drained", dut2.count, 0);
    cyc();
    // frame start mid-frame, then a full frame to exercise the wrap
    cam_valid = 1;
    cam_frame_start = 1;
    cam_data = 32'hF00;
    cyc();
    cam_frame_start = 0;
    for (int i = 1; i <= WORDS; i++) begin
      cam_data = i;
      @(negedge clk);
      if (i == 1) chk("fs_addr", ram_address, BASE);
      if (i == WORDS) chk("wrap_last", ram_address, BASE + WORDS - 1);
      cyc();
    end
    cam_valid = 0;
    @(negedge clk);
    chk("wrap_first", ram_address, BASE);
    chk("wrap_data", ram_data, WORDS);
    cyc(2);
    // reset asserted mid-burst with five queued pixels
    cpu_req = 1;
    for (int i = 0; i < 7; i++) begin
      cam_valid = i < 6;
      cam_data = 32'h500 + i;
      cyc();
    end
    reset = 1;
    cam_valid = 0;
    @(negedge clk);
    chk("pre_rst_state", dut.state, S_BURST);
    chk("pre_rst_count", dut.count, 5);
    cyc();
    cpu_req = 0;
    @(negedge clk);
    chk("mid_rst_count", dut.count, 0);
    chk("mid_rst_state", dut.state, S_CPU);
    chk("mid_rst_wren", ram_wren, 0);
    chk("mid_rst_ready", cam_ready, 1);
    chk("mid_rst_rvalid", cpu_rvalid, 0);
    chk("mid_rst_bcnt", dut.bcnt, 0);
    cyc();
    reset = 0;
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
